data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, is the number of wait cycles per access; the legal range is 1..15.
REQ-002 Parameter WORDS, default 256, is the number of 32-bit RAM words; it SHALL be a power of two.
REQ-003 Parameter BASE, default 32'h10000000, is the byte address of word 0.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port addr, input, 32 bits: byte address from the pipeline, held stable while stall=1.
REQ-007 Port data_in, input, 32 bits: store data, held stable while stall=1.
REQ-008 Port mem_read, input, 1 bit: load request.
REQ-009 Port mem_write, input, 1 bit: store request.
REQ-010 Port data_out, output, 32 bits: load result.
REQ-011 Port stall, output, 1 bit: while high, the pipeline SHALL hold its request and freeze.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.
REQ-013 Port addr_error, output, 1 bit: the current request is misaligned or out of range.

Function
REQ-014 The block SHALL have two states, IDLE and BUSY, plus a 4-bit down-counter cnt, a latched word index idx, latched write data, a latched op, and a 32-bit hold register.
REQ-015 A request SHALL be present when mem_read|mem_write=1.
REQ-016 A request SHALL be invalid when addr[1:0]!=0, addr<BASE, or addr>=BASE+4*WORDS.
REQ-017 IDLE with a valid request: stall=1 combinationally; at the edge, latch idx=(addr-BASE)>>2, latch data_in and op, set cnt=LATENCY-1, and go to BUSY.
REQ-018 IDLE with an invalid request: addr_error=1, done=1, and stall=0 in the same cycle; data_out=0; no RAM access; state stays IDLE.
REQ-019 IDLE with no request: stall=0, done=0, addr_error=0.
REQ-020 BUSY with cnt!=0: stall=1 and cnt decrements by one per cycle.
REQ-021 BUSY with cnt==0: done=1, stall=0; next state is IDLE.
REQ-022 Access latency: the request appears in cycle 0, stall is high in cycles 0..LATENCY-1, and done=1 in cycle LATENCY.
REQ-023 In the done cycle the request inputs are ignored, so that cycle SHALL NOT start a new access; the next request is sampled in the following IDLE cycle.
REQ-024 Store: RAM[idx] SHALL be written with the latched data at the edge ending the done cycle.
REQ-025 Load: in the done cycle data_out=RAM[idx] combinationally, and the hold register captures that value at the edge ending the done cycle.
REQ-026 Outside a load done cycle (and outside an invalid-request cycle), data_out SHALL equal the hold register.
REQ-027 Store done cycles SHALL NOT change the hold register.
REQ-028 If mem_read and mem_write are both 1, the store is performed; data_out in the done cycle is the pre-write RAM[idx], which is captured into the hold register.
REQ-029 Back-to-back accesses SHALL each take LATENCY+1 cycles, and a load following a store to the same word SHALL return the stored data.
REQ-030 The index SHALL use addr bits [2+log2(WORDS)-1:2] after the BASE offset; upper bits never wrap into range.

Reset
REQ-031 While reset=1 at an edge: state=IDLE, cnt=0, hold=0, and all RAM words are cleared to 0.
REQ-032 During reset, outputs SHALL be stall=0, done=0, addr_error=0, data_out=0.
REQ-033 A reset asserted in BUSY SHALL cancel the access; a pending store SHALL NOT be written, and the pipeline re-issues after reset.

Verification
REQ-034 Reset is applied, then released with no request -> stall=0, done=0, addr_error=0, data_out=0.
REQ-035 LATENCY=2: store 0xDEADBEEF to 0x10000004 -> stall=1 in cycles 0-1, done=1 in cycle 2; a following load of 0x10000004 -> done in its cycle 2 with data_out=0xDEADBEEF, held after the pulse.
REQ-036 Load 0x10000002 -> addr_error=1, done=1, stall=0 in the same cycle with data_out=0; a store to 0x10000400 is likewise rejected, and a later load of 0x100003FC returns 0.
REQ-037 Reset is asserted in cycle 1 of a store of 0x12345678 to 0x10000008 -> IDLE next cycle; a subsequent load of 0x10000008 returns 0.
REQ-038 Store 0xA5A5A5A5 to 0x10000010, then a request with mem_read=mem_write=1 to the same address with data_in=0x0F0F0F0F -> data_out=0xA5A5A5A5 in its done cycle; a later load returns 0x0F0F0F0F.
REQ-039 LATENCY=1: four back-to-back loads -> done every second cycle, and stall is never high in a done cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_responder : word RAM with fixed-latency stall/done handshake  (rev 1.0)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned WORDS   = 256,
  parameter logic [31:0] BASE    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        addr_error
);

  localparam int unsigned IDX_W    = $clog2(WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE} + 33'(WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      wdata;
  logic [31:0]      hold;
  logic             op_read;
  logic             op_write;
  logic [31:0]      ram [WORDS];

  logic             request;
  logic             invalid;
  logic             start;
  logic             finish;
  logic [31:0]      offset;
  logic             unused_offset_bits;

  assign request = mem_read | mem_write;
  assign offset  = addr - BASE;
  // 33-bit compare so BASE+4*WORDS near the top of the map cannot wrap
  assign invalid = (addr[1:0] != 2'b00) || (addr < BASE) || ({1'b0, addr} >= LIMIT);
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    addr_error = 1'b0;
    data_out   = hold;
    start      = 1'b0;
    finish     = 1'b0;
    if (reset) begin
      data_out = '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            if (invalid) begin
              addr_error = 1'b1;
              done       = 1'b1;
              data_out   = '0;
            end else begin
              stall      = 1'b1;
              start      = 1'b1;
              state_next = BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            stall = 1'b1;
          end else begin
            // done cycle: request inputs are deliberately ignored here
            done       = 1'b1;
            finish     = 1'b1;
            state_next = IDLE;
            if (op_read) begin
              data_out = ram[idx];
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      idx      <= '0;
      wdata    <= '0;
      op_read  <= 1'b0;
      op_write <= 1'b0;
      hold     <= '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
        ram[IDX_W'(i)] <= '0;
      end
    end else begin
      if (start) begin
        idx      <= offset[IDX_W+1:2];
        wdata    <= data_in;
        op_read  <= mem_read;
        op_write <= mem_write;
        cnt      <= CNT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // read-and-write requests capture the pre-write word into hold
      if (finish) begin
        if (op_write) begin
          ram[idx] <= wdata;
        end
        if (op_read) begin
          hold <= ram[idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_mem_responder : directed + random checks against a word-array model
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          WORDS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr0 = '0, din0 = '0, addr1 = '0, din1 = '0;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] dout0, dout1;
  logic        stall0, done0, err0, stall1, done1, err1;

  int          sel = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] mem_m [2][WORDS];
  logic [31:0] hold_m [2];

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(2), .WORDS(WORDS), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr0), .data_in(din0),
    .mem_read(rd0), .mem_write(wr0), .data_out(dout0),
    .stall(stall0), .done(done0), .addr_error(err0));

  data_mem_responder #(.LATENCY(1), .WORDS(WORDS), .BASE(BASE)) dut1 (
    .clk(clk), .reset(reset), .addr(addr1), .data_in(din1),
    .mem_read(rd1), .mem_write(wr1), .data_out(dout1),
    .stall(stall1), .done(done1), .addr_error(err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic es, input logic ed,
                           input logic ee, input logic [31:0] edata);
    check({tag, ".stall"}, 32'(sel != 0 ? stall1 : stall0), 32'(es));
    check({tag, ".done"},  32'(sel != 0 ? done1  : done0),  32'(ed));
    check({tag, ".err"},   32'(sel != 0 ? err1   : err0),   32'(ee));
    check({tag, ".data"},  sel != 0 ? dout1 : dout0, edata);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (sel != 0) begin
      rd1 = rd; wr1 = wr; addr1 = a; din1 = d;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
    end
  endtask

  function automatic bit in_map(input logic [31:0] a);
    longint ua = longint'(a);
    return (a[1:0] == 2'b00) && (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * WORDS);
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      hold_m[s] = '0;
      for (int w = 0; w < WORDS; w++) mem_m[s][w] = '0;
    end
  endtask

  // One complete access followed by one quiet cycle; entered and left at posedge+1.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int          lat = (sel != 0) ? 1 : 2;
    int          ix;
    logic [31:0] exp_data;
    drive(rd, wr, a, d);
    if (!in_map(a)) begin
      @(negedge clk);
      check_out({tag, ".reject"}, 1'b0, 1'b1, 1'b1, 32'h0);
    end else begin
      ix = int'((a - BASE) / 4);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        check_out({tag, ".wait"}, 1'b1, 1'b0, 1'b0, hold_m[sel]);
        @(posedge clk); #1;
      end
      @(negedge clk);
      exp_data = rd ? mem_m[sel][ix] : hold_m[sel];
      check_out({tag, ".done"}, 1'b0, 1'b1, 1'b0, exp_data);
      if (rd) hold_m[sel] = mem_m[sel][ix];
      if (wr) mem_m[sel][ix] = d;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    check_out({tag, ".after"}, 1'b0, 1'b0, 1'b0, hold_m[sel]);
    @(posedge clk); #1;
  endtask

  task automatic random_accesses(input int n);
    logic [31:0] a;
    int          k;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
        1:       a = BASE - 4 * $urandom_range(1, 4);
        2:       a = BASE + 4 * WORDS + 4 * $urandom_range(0, 3);
        default: a = BASE + 4 * $urandom_range(0, 15);
      endcase
      k = $urandom_range(0, 2);
      access(k != 1, k != 0, a, $urandom, "rand");
    end
  endtask

  initial begin
    clear_model();
    // reset held: outputs quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 0; check_out("in_reset", 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    sel = 0; check_out("post_reset0", 1'b0, 1'b0, 1'b0, 32'h0);
    sel = 1; check_out("post_reset1", 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;

    sel = 0;
    access(1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, "st_beef");
    access(1'b1, 1'b0, 32'h1000_0004, 32'h0, "ld_beef");
    check("beef_held", dout0, 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 32'h1000_0002, 32'h0, "ld_misaligned");
    access(1'b0, 1'b1, 32'h1000_0400, 32'h1111_2222, "st_past_end");
    access(1'b1, 1'b0, 32'h1000_03FC, 32'h0, "ld_last_word");
    access(1'b0, 1'b1, 32'h2000_0004, 32'h3333_4444, "st_high_alias");
    access(1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0, "ld_below_base");

    // reset lands in cycle 1 of a store: store dropped, RAM cleared
    drive(1'b0, 1'b1, 32'h1000_0008, 32'h1234_5678);
    @(negedge clk);
    check_out("rst_store.c0", 1'b1, 1'b0, 1'b0, hold_m[0]);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_out("rst_store.in_reset", 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_out("rst_store.idle", 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h1000_0008, 32'h0, "ld_after_rst");
    access(1'b1, 1'b0, 32'h1000_0004, 32'h0, "ld_beef_cleared");

    access(1'b0, 1'b1, 32'h1000_0010, 32'hA5A5_A5A5, "st_a5");
    access(1'b1, 1'b1, 32'h1000_0010, 32'h0F0F_0F0F, "rw_same");
    access(1'b1, 1'b0, 32'h1000_0010, 32'h0, "ld_0f");

    random_accesses(40);

    // LATENCY=1 instance: seed some words, then back-to-back loads
    sel = 1;
    for (int w = 0; w < 8; w++) access(1'b0, 1'b1, BASE + 4 * w, $urandom, "seed1");
    random_accesses(12);
    begin
      int ix;
      for (int c = 0; c < 8; c++) begin
        if (c % 2 == 0) begin
          ix = $urandom_range(0, 7);
          drive(1'b1, 1'b0, BASE + 4 * ix, 32'h0);
        end
        @(negedge clk);
        if (c % 2 == 0) begin
          check_out("b2b.req", 1'b1, 1'b0, 1'b0, hold_m[1]);
        end else begin
          check_out("b2b.done", 1'b0, 1'b1, 1'b0, mem_m[1][ix]);
          hold_m[1] = mem_m[1][ix];
        end
        @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check_out("b2b.idle", 1'b0, 1'b0, 1'b0, hold_m[1]);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
